// File: rtl/cpu_sys_bus_ctrl_if.sv
// Bus bundle between the CPU memory port, on-chip RAM, peripheral window
// and the system bus controller. The master side is the surrounding system
// (CPU, RAM and peripheral); the slave side is the controller itself.
interface cpu_sys_bus_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // CPU memory port
  logic                  cpu_mem_rd_en;
  logic                  cpu_mem_wr_en;
  logic [ADDR_WIDTH-1:0] cpu_mem_addr;
  logic [DATA_WIDTH-1:0] cpu_mem_wdata;
  logic [DATA_WIDTH-1:0] cpu_mem_rdata;
  logic                  cpu_stall;
  logic                  cpu_bus_err;
  // On-chip RAM port
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wd;
  logic [DATA_WIDTH-1:0] ram_rd;
  // Peripheral handshake port
  logic                  per_req;
  logic                  per_we;
  logic [ADDR_WIDTH-1:0] per_addr;
  logic [DATA_WIDTH-1:0] per_wdata;
  logic [DATA_WIDTH-1:0] per_rdata;
  logic                  per_ack;

  modport master (
    output cpu_mem_rd_en, cpu_mem_wr_en, cpu_mem_addr, cpu_mem_wdata,
    output ram_rd, per_rdata, per_ack,
    input  cpu_mem_rdata, cpu_stall, cpu_bus_err,
    input  ram_we, ram_addr, ram_wd,
    input  per_req, per_we, per_addr, per_wdata
  );

  modport slave (
    input  cpu_mem_rd_en, cpu_mem_wr_en, cpu_mem_addr, cpu_mem_wdata,
    input  ram_rd, per_rdata, per_ack,
    output cpu_mem_rdata, cpu_stall, cpu_bus_err,
    output ram_we, ram_addr, ram_wd,
    output per_req, per_we, per_addr, per_wdata
  );
endinterface

// File: rtl/cpu_sys_bus_ctrl.sv
// System bus controller behind the multicycle CPU memory port.
// Decodes each access into RAM (zero wait states), the peripheral window
// (req/ack handshake with timeout) or unmapped space (bus error).
module cpu_sys_bus_ctrl #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RAM_SIZE       = 32'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_BASE    = 32'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_SIZE    = 32'h0000_1000,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  cpu_sys_bus_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int                   CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // One extra bit so the window end cannot wrap around the address space
  localparam logic [ADDR_WIDTH:0]  PER_END  = {1'b0, PERIPH_BASE} + {1'b0, PERIPH_SIZE};

  state_t                state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [DATA_WIDTH-1:0] capture;

  logic acc;
  logic in_ram;
  logic in_per;

  assign acc    = bus.cpu_mem_rd_en | bus.cpu_mem_wr_en;
  assign in_ram = bus.cpu_mem_addr < RAM_SIZE;
  assign in_per = (bus.cpu_mem_addr >= PERIPH_BASE) &&
                  ({1'b0, bus.cpu_mem_addr} < PER_END);

  // RAM address and write data are simple pass-throughs of the CPU port
  assign bus.ram_addr = bus.cpu_mem_addr;
  assign bus.ram_wd   = bus.cpu_mem_wdata;

  // Transaction FSM: launches the peripheral handshake, counts wait cycles
  // and captures read data; every peripheral-side output is registered here
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      capture       <= '0;
      bus.per_req   <= 1'b0;
      bus.per_we    <= 1'b0;
      bus.per_addr  <= '0;
      bus.per_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc && in_per) begin
            bus.per_req   <= 1'b1;
            bus.per_we    <= bus.cpu_mem_wr_en;
            bus.per_addr  <= bus.cpu_mem_addr - PERIPH_BASE;
            bus.per_wdata <= bus.cpu_mem_wdata;
            wait_cnt      <= '0;
            state         <= ST_WAIT;
          end else if (acc && !in_ram) begin
            state <= ST_ERR;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (bus.per_ack) begin
            if (!bus.per_we) begin
              capture <= bus.per_rdata;
            end
            bus.per_req <= 1'b0;
            state       <= ST_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            bus.per_req <= 1'b0;
            state       <= ST_ERR;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // CPU-facing responses; held quiet while reset is asserted so a CPU still
  // presenting a peripheral address does not see a stall during reset
  always_comb begin
    bus.ram_we        = 1'b0;
    bus.cpu_stall     = 1'b0;
    bus.cpu_bus_err   = 1'b0;
    bus.cpu_mem_rdata = '0;
    if (sys_rst_n) begin
      case (state)
        ST_IDLE: begin
          bus.ram_we    = bus.cpu_mem_wr_en & in_ram;
          bus.cpu_stall = acc & ~in_ram;
          if (in_ram) begin
            bus.cpu_mem_rdata = bus.ram_rd;
          end
        end
        ST_WAIT: bus.cpu_stall = 1'b1;
        ST_DONE: bus.cpu_mem_rdata = capture;
        ST_ERR:  bus.cpu_bus_err = 1'b1;
        default: bus.cpu_stall = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/cpu_sys_bus_ctrl.md
Name: cpu_sys_bus_ctrl

Overview:
System bus controller directly downstream of the multicycle CPU memory port. It decodes each CPU access into one of three regions: on-chip RAM, peripheral window, or unmapped. RAM accesses pass straight through with zero wait states. Peripheral accesses run a req/ack handshake that stalls the CPU, with a timeout and a bus-error report; unmapped accesses raise a bus error.

Parameters:
ADDR_WIDTH, 32, address bus width.
DATA_WIDTH, 32, data bus width.
RAM_SIZE, 32'h0000_1000, RAM region is byte addresses [0, RAM_SIZE).
PERIPH_BASE, 32'h4000_0000, peripheral window base.
PERIPH_SIZE, 32'h0000_1000, peripheral window is [PERIPH_BASE, PERIPH_BASE+PERIPH_SIZE).
TIMEOUT_CYCLES, 16, max WAIT cycles before error (>=1).

Ports:
sys_clk  in  1  system clock; all state on rising edge.
sys_rst_n  in  1  asynchronous active-low reset.
cpu_mem_rd_en  in  1  CPU read request, level.
cpu_mem_wr_en  in  1  CPU write request, level.
cpu_mem_addr  in  ADDR_WIDTH  CPU byte address.
cpu_mem_wdata  in  DATA_WIDTH  CPU write data.
cpu_mem_rdata  out  DATA_WIDTH  read data to the CPU.
cpu_stall  out  1  CPU must hold its address and controls, and must not advance.
cpu_bus_err  out  1  one-cycle error pulse.
ram_we  out  1  RAM write enable.
ram_addr  out  ADDR_WIDTH  RAM address.
ram_wd  out  DATA_WIDTH  RAM write data.
ram_rd  in  DATA_WIDTH  RAM read data.
per_req  out  1  peripheral request, registered.
per_we  out  1  peripheral write qualifier, registered.
per_addr  out  ADDR_WIDTH  address offset from PERIPH_BASE, registered.
per_wdata  out  DATA_WIDTH  registered write data.
per_rdata  in  DATA_WIDTH  peripheral read data, valid with per_ack.
per_ack  in  1  peripheral completion, single cycle.

Behaviour:
- Interface: one clock, sys_clk; reset sys_rst_n is asynchronous, active-low.
- Reset values:
  - State is IDLE; timeout counter is 0.
  - per_req=0, per_we=0, per_addr=0, per_wdata=0, capture register=0.
  - cpu_stall=0, cpu_bus_err=0, ram_we=0, cpu_mem_rdata=0.
- Reset asserted mid-transaction aborts it immediately: per_req drops asynchronously and no error is reported.
- Access: acc = cpu_mem_rd_en | cpu_mem_wr_en. If both are high, the access is treated as a write.
- Decode (combinational, unsigned compares): in_ram, in_per, else unmapped.
- RAM path, active only in IDLE:
  - ram_addr = cpu_mem_addr; ram_wd = cpu_mem_wdata.
  - ram_we = cpu_mem_wr_en & in_ram.
  - cpu_mem_rdata = ram_rd when in_ram, else 0.
  - No stall and no state change.
- FSM with states IDLE, WAIT, DONE, ERR:
  - IDLE, acc & in_per: cpu_stall=1. Next edge: latch per_addr = addr - PERIPH_BASE, per_we, per_wdata; set per_req=1; clear the counter; go to WAIT.
  - IDLE, acc & unmapped: cpu_stall=1; next state is ERR.
  - WAIT: cpu_stall=1; per_req held at 1; counter increments each cycle.
    - per_ack=1 sampled: capture per_rdata (reads only), clear per_req, go to DONE.
    - Else, counter == TIMEOUT_CYCLES-1: clear per_req, go to ERR.
    - per_ack and timeout in the same cycle: ack wins.
  - DONE: cpu_stall=0; cpu_mem_rdata = capture register; then IDLE.
  - ERR: cpu_stall=0; cpu_bus_err=1; cpu_mem_rdata=0; then IDLE.
- Total latency:
  - RAM access: 0 stall cycles.
  - Peripheral access with ack in the k-th WAIT cycle: k+1 stall cycles, then one DONE cycle.
  - Unmapped access: 1 stall cycle, then ERR.
- Boundary cases:
  - Late per_ack outside WAIT is ignored.
  - ram_we is always 0 outside IDLE.
  - Address RAM_SIZE-1 decodes as RAM; RAM_SIZE decodes as unmapped.
  - PERIPH_BASE+PERIPH_SIZE-1 decodes as peripheral.
  - An address at or above PERIPH_BASE+PERIPH_SIZE is unmapped, with no wrap-around.
  - A new peripheral access presented in DONE or ERR is taken on the following IDLE cycle.

Test Plan:
1. RAM write then read: wr addr 0x10, data 0xA5A5_0001 -> ram_we=1 for one cycle, cpu_stall=0. Then rd 0x10 with ram_rd=0xA5A5_0001 -> cpu_mem_rdata=0xA5A5_0001 in the same cycle.
2. Peripheral read, ack on the 3rd WAIT cycle with per_rdata=0x1234_5678 -> per_addr=0x8 for addr 0x4000_0008; cpu_stall high 4 cycles; DONE shows 0x1234_5678; cpu_bus_err stays 0.
3. Peripheral write at 0x4000_0FFC, data 0xCAFE_F00D, ack in the 1st WAIT cycle -> per_we=1, per_wdata=0xCAFE_F00D; per_req high exactly 1 cycle; ram_we stays 0.
4. Peripheral timeout, no ack -> per_req high 16 cycles, then ERR with cpu_bus_err=1 for one cycle and cpu_mem_rdata=0. A subsequent stray per_ack is ignored.
5. Unmapped read at 0x0000_1000 and at 0x4000_1000 -> 1 stall cycle, then cpu_bus_err pulse with rdata=0. Unmapped write at 0x2000_0000 -> same, and no ram_we or per_req.
6. Reset asserted during WAIT (cycle 2) -> per_req and cpu_stall drop to 0 asynchronously; after release the state is IDLE and a RAM read works with 0 stall.
